// File: rtl/wb_buffered_stage_pkg.sv
// Shared types for the buffered write-back stage.
//   mem_op_t   : memory operation of a retiring instruction
//   wb_entry_t : one queued register-file write {we, addr, data}
//   is_store() : true for operations that never write a register
package wb_buffered_stage_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LW   = 4'd1,
    MEM_OP_SW   = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LB   = 4'd5,
    MEM_OP_LBU  = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SB   = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational write-value former for the write-back stage.
// Ports:
//   mem_op_i      : memory operation of the retiring instruction
//   byte_off_i    : effective address bits [1:0]
//   load_data_i   : aligned memory word (little-endian lanes, byte 0 = [7:0])
//   alu_result_i  : ALU result, used for non-load instructions
//   data_o        : value to write into the register file
//   misaligned_o  : LW with byte_off != 0, or LH/LHU with byte_off[0] set
module wb_load_align
  import wb_buffered_stage_pkg::*;
(
  input  mem_op_t              mem_op_i,
  input  logic [1:0]           byte_off_i,
  input  logic [WB_DATA_W-1:0] load_data_i,
  input  logic [WB_DATA_W-1:0] alu_result_i,
  output logic [WB_DATA_W-1:0] data_o,
  output logic                 misaligned_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = byte_off_i[1] ? load_data_i[31:16] : load_data_i[15:0];
  assign byte_sel = load_data_i[{byte_off_i, 3'b000} +: 8];

  always_comb begin
    data_o       = alu_result_i;
    misaligned_o = 1'b0;
    case (mem_op_i)
      MEM_OP_LW: begin
        data_o       = load_data_i;
        misaligned_o = (byte_off_i != 2'b00);
      end
      MEM_OP_LH: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = byte_off_i[0];
      end
      MEM_OP_LHU: begin
        data_o       = {16'h0000, half_sel};
        misaligned_o = byte_off_i[0];
      end
      MEM_OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data_o = {24'h000000, byte_sel};
      default:    data_o = alu_result_i;
    endcase
  end

endmodule

// File: rtl/wb_buffered_stage.sv
// Buffered MIPS write-back stage.
// Accepts one retiring instruction per cycle, forms its register-file write
// value, and queues it in a DEPTH-entry FIFO drained into the register file.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : retire handshake from MEM
//   in_mem_op .. in_byte_off : payload of the retiring instruction
//   rf_we/rf_waddr/rf_wdata  : register-file write from the FIFO head
//   rf_ready                 : register-file port accepts the write
//   fwd_raddr/fwd_hit/fwd_data : youngest-match bypass over queued writes
//   done_out                 : pulse per retired (popped) instruction
//   err_misaligned           : pulse the cycle after a misaligned load is accepted
//   retired_count            : wrapping count of retired instructions
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready = !full and is a function of the occupancy register only. A full
// FIFO refuses input even if it pops in the same cycle.
//
// Entry fields are sized by the package widths; DATA_W/ADDR_W are expected to
// keep their defaults (sub-word loads need a 32-bit datapath).
module wb_buffered_stage
  import wb_buffered_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  mem_op_t           in_mem_op,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_reg_dest,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic [1:0]        in_byte_off,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              done_out,
  output logic              err_misaligned,
  output logic [31:0]       retired_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] wr_data;
  logic              misaligned;

  wb_load_align u_align (
    .mem_op_i     (in_mem_op),
    .byte_off_i   (in_byte_off),
    .load_data_i  (in_load_data),
    .alu_result_i (in_alu_result),
    .data_o       (wr_data),
    .misaligned_o (misaligned)
  );

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         new_entry;
  wb_entry_t         head;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       retired_count_q, retired_count_d;
  logic              err_q, err_d;
  logic              full, empty, push, pop;
  logic [PTR_W-1:0]  scan_idx;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[head_q];
  // Non-writing entries leave without waiting for the register-file port.
  assign pop   = !empty && (!head.we || rf_ready);

  // Misaligned loads and stores still retire, but never write.
  always_comb begin
    new_entry      = '0;
    new_entry.we   = in_reg_write && (in_reg_dest != '0) && !misaligned &&
                     !is_store(in_mem_op);
    new_entry.addr = in_reg_dest;
    new_entry.data = wr_data;
  end

  always_comb begin
    head_d          = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d          = push ? tail_q + PTR_W'(1) : tail_q;
    count_d         = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    retired_count_d = pop ? retired_count_q + 32'd1 : retired_count_q;
    err_d           = push && misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      retired_count_q <= '0;
      err_q           <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      retired_count_q <= retired_count_d;
      err_q           <= err_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[tail_q] <= new_entry;
  end

  assign in_ready       = !full;
  assign rf_we          = !empty && head.we;
  assign rf_waddr       = empty ? '0 : head.addr;
  assign rf_wdata       = empty ? '0 : head.data;
  assign done_out       = pop;
  assign err_misaligned = err_q;
  assign retired_count  = retired_count_q;

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && mem_q[scan_idx].we &&
          (mem_q[scan_idx].addr == fwd_raddr) && (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[scan_idx].data;
      end
    end
  end

endmodule

// File: tb/tb_wb_buffered_stage.sv
// Directed bench for wb_buffered_stage: linear steps with hand-computed values.
module tb_wb_buffered_stage;
  import wb_buffered_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  mem_op_t     in_mem_op;
  logic        in_reg_write;
  logic [4:0]  in_reg_dest;
  logic [31:0] in_alu_result;
  logic [31:0] in_load_data;
  logic [1:0]  in_byte_off;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        done_out;
  logic        err_misaligned;
  logic [31:0] retired_count;

  int vectors = 0;
  int miscompares = 0;

  wb_buffered_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_op      (in_mem_op),
    .in_reg_write   (in_reg_write),
    .in_reg_dest    (in_reg_dest),
    .in_alu_result  (in_alu_result),
    .in_load_data   (in_load_data),
    .in_byte_off    (in_byte_off),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .rf_ready       (rf_ready),
    .fwd_raddr      (fwd_raddr),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data),
    .done_out       (done_out),
    .err_misaligned (err_misaligned),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input mem_op_t op, input logic wr, input logic [4:0] dest,
                      input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] off);
    in_valid      = 1'b1;
    in_mem_op     = op;
    in_reg_write  = wr;
    in_reg_dest   = dest;
    in_alu_result = alu;
    in_load_data  = ld;
    in_byte_off   = off;
    tick();
    in_valid      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mem_op = MEM_OP_NONE; in_reg_write = 1'b0;
    in_reg_dest = '0; in_alu_result = '0; in_load_data = '0; in_byte_off = '0;
    rf_ready = 1'b0; fwd_raddr = 5'd3;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_misaligned, 0);
    chk("rst_count", retired_count, 0);

    // Backpressure with DEPTH=2
    push(MEM_OP_NONE, 1, 5'd3, 32'd5, 32'h0, 2'd0);
    chk("bp_ready_1", in_ready, 1);
    chk("bp_we_1", rf_we, 1);
    chk("bp_waddr_1", rf_waddr, 3);
    chk("bp_wdata_1", rf_wdata, 5);
    push(MEM_OP_NONE, 1, 5'd4, 32'd6, 32'h0, 2'd0);
    chk("bp_ready_full", in_ready, 0);
    push(MEM_OP_NONE, 1, 5'd9, 32'd9, 32'h0, 2'd0);
    chk("bp_still_full", in_ready, 0);
    chk("bp_head_kept", rf_waddr, 3);
    rf_ready = 1'b1;
    #1;
    chk("bp_done_a", done_out, 1);
    chk("bp_wdata_a", rf_wdata, 5);
    tick();
    chk("bp_waddr_b", rf_waddr, 4);
    chk("bp_wdata_b", rf_wdata, 6);
    chk("bp_done_b", done_out, 1);
    tick();
    chk("bp_drained_we", rf_we, 0);
    chk("bp_drained_done", done_out, 0);
    chk("bp_count", retired_count, 2);
    chk("bp_ready_after", in_ready, 1);

    // Sub-word loads
    rf_ready = 1'b0;
    push(MEM_OP_LB, 1, 5'd5, 32'hDEAD, 32'h80FF_7F01, 2'd3);
    chk("lb_we", rf_we, 1);
    chk("lb_waddr", rf_waddr, 5);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_hold_done", done_out, 0);
    rf_ready = 1'b1;
    #1;
    chk("lb_done", done_out, 1);
    tick();
    chk("lb_count", retired_count, 3);
    push(MEM_OP_LBU, 1, 5'd6, 32'hDEAD, 32'h80FF_7F01, 2'd3);
    chk("lbu_wdata", rf_wdata, 32'h0000_0080);
    chk("lbu_done", done_out, 1);
    tick();
    push(MEM_OP_LH, 1, 5'd7, 32'hDEAD, 32'h80FF_7F01, 2'd2);
    chk("lh_wdata", rf_wdata, 32'hFFFF_80FF);
    tick();
    push(MEM_OP_LHU, 1, 5'd8, 32'hDEAD, 32'h80FF_7F01, 2'd0);
    chk("lhu_wdata", rf_wdata, 32'h0000_7F01);
    chk("lhu_err", err_misaligned, 0);
    tick();
    chk("ld_count", retired_count, 6);

    // Youngest-match bypass
    rf_ready = 1'b0;
    push(MEM_OP_NONE, 1, 5'd7, 32'd1, 32'h0, 2'd0);
    push(MEM_OP_NONE, 1, 5'd7, 32'd2, 32'h0, 2'd0);
    fwd_raddr = 5'd7; #1;
    chk("byp_hit", fwd_hit, 1);
    chk("byp_young", fwd_data, 2);
    fwd_raddr = 5'd0; #1;
    chk("byp_r0_hit", fwd_hit, 0);
    chk("byp_r0_data", fwd_data, 0);
    fwd_raddr = 5'd8; #1;
    chk("byp_miss", fwd_hit, 0);
    fwd_raddr = 5'd7;
    rf_ready = 1'b1;
    tick();
    chk("byp_one_left", fwd_data, 2);
    tick();
    chk("byp_empty", fwd_hit, 0);
    rf_ready = 1'b0;
    push(MEM_OP_NONE, 1, 5'd7, 32'd3, 32'h0, 2'd0);
    push(MEM_OP_NONE, 1, 5'd8, 32'd4, 32'h0, 2'd0);
    fwd_raddr = 5'd7; #1;
    chk("byp_older", fwd_data, 3);
    fwd_raddr = 5'd8; #1;
    chk("byp_newer", fwd_data, 4);
    rf_ready = 1'b1;
    tick(); tick();
    chk("byp_count", retired_count, 10);

    // Non-writing retires
    rf_ready = 1'b0;
    push(MEM_OP_SW, 0, 5'd9, 32'h100, 32'h0, 2'd0);
    chk("nw_sw_we", rf_we, 0);
    chk("nw_sw_done", done_out, 1);
    chk("nw_sw_err", err_misaligned, 0);
    push(MEM_OP_NONE, 1, 5'd0, 32'h77, 32'h0, 2'd0);
    chk("nw_r0_we", rf_we, 0);
    chk("nw_r0_done", done_out, 1);
    chk("nw_r0_err", err_misaligned, 0);
    push(MEM_OP_LW, 1, 5'd10, 32'h0, 32'h1234_5678, 2'd2);
    chk("nw_lw_we", rf_we, 0);
    chk("nw_lw_done", done_out, 1);
    chk("nw_lw_err", err_misaligned, 1);
    tick();
    chk("nw_end_done", done_out, 0);
    chk("nw_end_err", err_misaligned, 0);
    chk("nw_count", retired_count, 13);

    // Reset with two queued entries
    push(MEM_OP_NONE, 1, 5'd10, 32'd11, 32'h0, 2'd0);
    push(MEM_OP_NONE, 1, 5'd11, 32'd12, 32'h0, 2'd0);
    chk("mr_full", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_we", rf_we, 0);
    chk("mr_done", done_out, 0);
    chk("mr_count", retired_count, 0);
    chk("mr_ready", in_ready, 1);
    rf_ready = 1'b1; #1;
    chk("mr_done_rdy", done_out, 0);
    tick();
    chk("mr_count_after", retired_count, 0);
    rf_ready = 1'b0;
    rst = 1'b1;
    push(MEM_OP_NONE, 1, 5'd12, 32'd13, 32'h0, 2'd0);
    rst = 1'b0;
    chk("mr_hs_ignored_we", rf_we, 0);
    chk("mr_hs_ignored_rdy", in_ready, 1);

    // Counter wrap
    rf_ready = 1'b1;
    push(MEM_OP_NONE, 1, 5'd12, 32'h55, 32'h0, 2'd0);
    chk("wrap_done", done_out, 1);
    force dut.retired_count_q = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preload", retired_count, 32'hFFFF_FFFF);
    release dut.retired_count_q;
    tick();
    chk("wrap_count", retired_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
